// File: rtl/trade_pkg.sv
// Shared types for the order generator: FSM states, side encoding
// and the signed position width.
package trade_pkg;

  localparam int POS_W = 8;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } order_state_t;

endpackage

// File: rtl/trade_order_gen_risk.sv
// trade_risk_check: combinational position-limit check done in
// 9-bit signed so position +/- qty can never wrap.
module trade_risk_check
  import trade_pkg::*;
#(
  parameter int max_position = 4
) (
  input  logic [POS_W-1:0] position,
  input  logic             side,
  input  logic [6:0]       qty,
  output logic             allowed
);

  logic signed [8:0] pos9;
  logic signed [8:0] qty9;
  logic signed [8:0] lim9;
  logic signed [8:0] nxt9;

  always_comb begin
    pos9 = $signed({position[POS_W-1], position});
    qty9 = $signed({2'b00, qty});
    lim9 = $signed(9'(max_position));
    if (side == SIDE_BUY) begin
      nxt9    = pos9 + qty9;
      allowed = (nxt9 <= lim9);
    end else begin
      nxt9    = pos9 - qty9;
      allowed = (nxt9 >= -lim9);
    end
  end

endmodule

// File: rtl/trade_order_gen.sv
// Order generator: limit-checked buy/sell orders under valid/ready.
// Optional post-fill cooldown enabled by TRADE_COOLDOWN_EN.
module trade_order_gen
  import trade_pkg::*;
#(
  parameter int data_width      = 8,
  parameter int max_position    = 4,
  parameter int order_qty       = 1,
  parameter int cooldown_cycles = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid_mean,
  input  logic                  buy_signal,
  input  logic                  sell_signal,
  input  logic [data_width-1:0] current_data,
  input  logic                  order_ready,
  output logic                  order_valid,
  output logic                  order_side,
  output logic [data_width-1:0] order_price,
  output logic [POS_W-1:0]      position,
  output logic [15:0]           drop_count
);

  localparam logic [POS_W-1:0] QTY = POS_W'(order_qty);

  order_state_t          state_q, state_d;
  logic                  side_q, side_d;
  logic [data_width-1:0] price_q, price_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic [15:0]           drop_q, drop_d;
  logic                  drop_inc;
  logic                  single, conflict, any_dec;
  logic                  allowed;

`ifdef TRADE_COOLDOWN_EN
  localparam logic [15:0] CD = 16'(cooldown_cycles);
  logic [15:0] cnt_q, cnt_d;
`else
  wire unused_cooldown = |cooldown_cycles;
`endif

  assign single   = data_valid_mean & (buy_signal ^ sell_signal);
  assign conflict = data_valid_mean & buy_signal & sell_signal;
  assign any_dec  = data_valid_mean & (buy_signal | sell_signal);

  trade_risk_check #(
    .max_position(max_position)
  ) u_risk (
    .position(pos_q),
    .side    (buy_signal ? SIDE_BUY : SIDE_SELL),
    .qty     (QTY[6:0]),
    .allowed (allowed)
  );

  always_comb begin
    state_d  = state_q;
    side_d   = side_q;
    price_d  = price_q;
    pos_d    = pos_q;
    drop_inc = 1'b0;
`ifdef TRADE_COOLDOWN_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (conflict) begin
          drop_inc = 1'b1;
        end else if (single) begin
          if (allowed) begin
            state_d = ISSUE;
            side_d  = buy_signal ? SIDE_BUY : SIDE_SELL;
            price_d = current_data;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      ISSUE: begin
        drop_inc = any_dec;
        if (order_ready) begin
          pos_d = (side_q == SIDE_BUY) ? pos_q + QTY : pos_q - QTY;
`ifdef TRADE_COOLDOWN_EN
          if (CD != 16'd0) begin
            state_d = COOLDOWN;
            cnt_d   = CD;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef TRADE_COOLDOWN_EN
      COOLDOWN: begin
        drop_inc = any_dec;
        if (cnt_q <= 16'd1) begin
          state_d = IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      side_q  <= 1'b0;
      price_q <= '0;
      pos_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      price_q <= price_d;
      pos_q   <= pos_d;
      drop_q  <= drop_d;
    end
  end

`ifdef TRADE_COOLDOWN_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign order_valid = (state_q == ISSUE);
  assign order_side  = side_q;
  assign order_price = price_q;
  assign position    = pos_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_trade_order_gen.sv
// Scoreboard bench for trade_order_gen: expected orders are queued at
// stimulus time and popped by a monitor on each handshake.
module tb_trade_order_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_valid_mean = 1'b0;
  logic       buy_signal = 1'b0;
  logic       sell_signal = 1'b0;
  logic [7:0] current_data = 8'd0;
  logic       order_ready = 1'b0;
  logic       order_valid;
  logic       order_side;
  logic [7:0] order_price;
  logic [7:0] position;
  logic [15:0] drop_count;

  int total = 0;
  int passed = 0;

  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  trade_order_gen dut (
    .clk            (clk),
    .rst            (rst),
    .data_valid_mean(data_valid_mean),
    .buy_signal     (buy_signal),
    .sell_signal    (sell_signal),
    .current_data   (current_data),
    .order_ready    (order_ready),
    .order_valid    (order_valid),
    .order_side     (order_side),
    .order_price    (order_price),
    .position       (position),
    .drop_count     (drop_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic decide(input logic b, input logic s, input logic [7:0] p,
                        input logic accept);
    data_valid_mean = 1'b1;
    buy_signal      = b;
    sell_signal     = s;
    current_data    = p;
    if (accept) exp_q.push_back({b, p});
    step(1);
    data_valid_mean = 1'b0;
    buy_signal      = 1'b0;
    sell_signal     = 1'b0;
  endtask

  // Monitor: pops on handshake and checks hold stability while stalled.
  logic       hold_prev = 1'b0;
  logic       side_prev = 1'b0;
  logic [7:0] price_prev = 8'd0;
  logic [8:0] e;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && order_valid) begin
        chk("hold_side", 32'(order_side), 32'(side_prev));
        chk("hold_price", 32'(order_price), 32'(price_prev));
      end
      if (order_valid && order_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_order: got side %0d price %0d expected none",
                   order_side, order_price);
        end else begin
          e = exp_q.pop_front();
          chk("order_side", 32'(order_side), 32'(e[8]));
          chk("order_price", 32'(order_price), 32'(e[7:0]));
        end
      end
      hold_prev  = order_valid && !order_ready;
      side_prev  = order_side;
      price_prev = order_price;
    end
  end

  initial begin
    step(3);
    chk("rst_valid", 32'(order_valid), 0);
    chk("rst_side", 32'(order_side), 0);
    chk("rst_price", 32'(order_price), 0);
    chk("rst_pos", 32'(position), 0);
    chk("rst_drop", 32'(drop_count), 0);
    rst = 1'b0;
    order_ready = 1'b1;
    step(2);

    // Single buy with ready already high.
    decide(1'b1, 1'b0, 8'd40, 1'b1);
    chk("t1_valid", 32'(order_valid), 1);
    step(1);
    chk("t1_valid_low", 32'(order_valid), 0);
    chk("t1_pos", 32'(position), 1);
    step(8);

    // Stalled sell, held for 5 cycles.
    order_ready = 1'b0;
    decide(1'b0, 1'b1, 8'd55, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_hold", 32'(order_valid), 1);
      chk("t2_pos_hold", 32'(position), 1);
      step(1);
    end
    order_ready = 1'b1;
    chk("t2_pos_pre", 32'(position), 1);
    step(1);
    chk("t2_valid_low", 32'(order_valid), 0);
    chk("t2_pos", 32'(position), 0);
    step(8);

    // Position limit: 4 buys fill, 5th dropped, then a sell.
    for (int i = 0; i < 4; i++) begin
      decide(1'b1, 1'b0, 8'(10 + i), 1'b1);
      step(8);
      chk("t3_pos", 32'(position), 32'(i + 1));
    end
    decide(1'b1, 1'b0, 8'd14, 1'b0);
    chk("t3_no_order", 32'(order_valid), 0);
    chk("t3_drop", 32'(drop_count), 1);
    step(8);
    chk("t3_pos_lim", 32'(position), 4);
    decide(1'b0, 1'b1, 8'd20, 1'b1);
    step(8);
    chk("t3_pos_sell", 32'(position), 3);

    // Conflicting decision.
    decide(1'b1, 1'b1, 8'd99, 1'b0);
    chk("t4_no_order", 32'(order_valid), 0);
    chk("t4_drop", 32'(drop_count), 2);
    step(4);

    // Cooldown window: accepted at M-1, probes at M+2 and M+5.
    decide(1'b0, 1'b1, 8'd30, 1'b1);
    step(2);
`ifdef TRADE_COOLDOWN_EN
    decide(1'b0, 1'b1, 8'd31, 1'b0);
`else
    decide(1'b0, 1'b1, 8'd31, 1'b1);
`endif
    step(2);
    decide(1'b0, 1'b1, 8'd32, 1'b1);
    step(8);
`ifdef TRADE_COOLDOWN_EN
    chk("t5_drop", 32'(drop_count), 3);
    chk("t5_pos", 32'(position), 1);
`else
    chk("t5_drop", 32'(drop_count), 2);
    chk("t5_pos", 32'(position), 0);
`endif

    // Reset while an order is pending.
    order_ready = 1'b0;
    decide(1'b1, 1'b0, 8'd50, 1'b1);
    chk("t6_valid", 32'(order_valid), 1);
    rst = 1'b1;
    exp_q.delete();
    step(1);
    chk("t6_valid_rst", 32'(order_valid), 0);
    chk("t6_pos_rst", 32'(position), 0);
    chk("t6_drop_rst", 32'(drop_count), 0);
    chk("t6_price_rst", 32'(order_price), 0);
    rst = 1'b0;
    order_ready = 1'b1;
    step(5);
    chk("t6_no_stale", 32'(order_valid), 0);
    chk("t6_pos_after", 32'(position), 0);

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
